slave_serial_port: RTL and testbench
====================================

// Module: slave_serial_port
// PURPOSE
// - Slave-side responder of the serial system bus: receives bit-serial write/read frames routed from the granted master.
// - Holds a local register file and returns read data bit-serially on slave_valid/tx_data.
// - Outputs feed the per-slave inputs of the slave-to-master mux (slave_valid_n, slave_ready_n, tx_data_n).
// PARAMETERS
// - ADDR_WIDTH  4   register-file address bits; depth = 2**ADDR_WIDTH
// - DATA_WIDTH  8   register width, bits per data phase
// - TIMEOUT     16  idle-gap cycles mid-frame before abort; 0 = never abort
// PORTS
// - clk         in   1           system clock, all logic on rising edge
// - rst         in   1           synchronous reset, active-high
// - bus_valid   in   1           bus_data carries a frame bit this cycle
// - bus_data    in   1           serial frame bit from master mux
// - slave_ready out  1           slave accepts frame bits this cycle
// - slave_valid out  1           tx_data carries a read-data bit
// - tx_data     out  1           serial read data, LSB first
// - rx_done     out  1           1-cycle pulse: write committed
// - parity_err  out  1           1-cycle pulse: frame dropped on parity mismatch
// BEHAVIOUR
// - Clocking: one clock (clk); reset is synchronous and active-high (rst).
// - Reset: all outputs 0; state IDLE; counters 0; register file cleared to 0.
//   slave_ready rises the first cycle after rst deasserts.
// - Bit acceptance: a bit is taken only when bus_valid=1 and slave_ready=1.
//   Bits with bus_valid=1 while slave_ready=0 are ignored.
// - Frame format, all fields LSB first:
//   - MODE: 1 bit, 1=write, 0=read.
//   - ADDR: ADDR_WIDTH bits.
//   - WDATA: DATA_WIDTH bits, write frames only.
//   - [PARITY]: 1 bit, only with the macro.
// - IDLE: slave_ready=1. The first accepted bit is MODE -> ADDR.
// - ADDR: bit counter 0..ADDR_WIDTH-1. After the last bit:
//   - write -> WDATA
//   - read -> RD_WAIT (or PAR, with the macro)
// - WDATA: DATA_WIDTH bits, then COMMIT (or PAR).
// - COMMIT (1 cycle, slave_ready=0): mem[addr] <= wdata; rx_done=1 this cycle; next IDLE.
// - RD_WAIT (1 cycle, slave_ready=0): rdata register <= mem[addr]; next TX.
// - TX: DATA_WIDTH consecutive cycles with slave_valid=1 and tx_data=rdata[i], i=0 first.
//   slave_ready=0; no stalling; then IDLE.
// - Latency:
//   - last write bit -> rx_done: 1 cycle
//   - last read-frame bit -> first slave_valid: 2 cycles (RD_WAIT, then TX)
// - Gaps: inside ADDR/WDATA/PAR, cycles with bus_valid=0 hold state and counters; a gap counter runs.
//   - The gap counter resets on every accepted bit.
//   - When it reaches TIMEOUT (TIMEOUT>0): abort to IDLE, no write, no pulse outputs.
// - Read-after-write to the same address in back-to-back frames returns the new data.
// - Address wraps naturally at ADDR_WIDTH bits; no out-of-range case.
// - rst asserted mid-frame or mid-TX: immediate return to IDLE; outputs 0 next cycle; partial frame discarded.
// CONFIGURATION
// - SLAVE_PARITY_EN defined:
//   - Frame ends with one extra bit (state PAR) giving even parity over MODE+ADDR (+WDATA).
//   - On a match, continue to COMMIT / RD_WAIT.
//   - On a mismatch: parity_err=1 for 1 cycle, no write, no read response, return to IDLE.
// - SLAVE_PARITY_EN undefined: no PAR state, frames end after the last ADDR/WDATA bit, parity_err tied 0.
// TESTING
// - Reset: hold rst 3 cycles -> all outputs 0; slave_ready=1 on the first cycle after release.
// - Write then read: write frame addr=4'h5, data=8'hA7.
//   -> rx_done pulse 1 cycle after the last bit.
//   -> Read frame addr=4'h5 -> 8 slave_valid cycles, tx_data=1,1,1,0,0,1,0,1.
// - Gaps/timeout (TIMEOUT=16): insert a 5-cycle bus_valid=0 gap mid-ADDR -> frame completes normally.
//   A 16-cycle gap -> abort: no rx_done, mem unchanged, slave_ready=1.
// - Ignored bits: drive bus_valid=1 during RD_WAIT/TX -> no effect on the current read; a new frame starts only after TX ends.
// - Reset mid-TX: assert rst at TX bit 3 -> slave_valid=0 next cycle, IDLE; register file cleared (a re-read returns 8'h00).
// - Parity (SLAVE_PARITY_EN): write addr=4'h2, data=8'h01 with a wrong parity bit -> parity_err pulse, no rx_done, mem[2] stays 8'h00.
//   Correct parity -> rx_done.

Source files
------------

// File: rtl/slave_serial_port.sv
// slave_serial_port
// Slave-side responder on the bit-serial system bus. The slave receives
// write and read frames from the granted master. It keeps a small local
// register file, and it returns read data bit-serially, LSB first.
//
// Frame layout (every field LSB first):
//   MODE (1 = write, 0 = read), ADDR[ADDR_WIDTH], WDATA[DATA_WIDTH] on writes,
//   then one optional even-parity bit.
//
// Optional feature macro: SLAVE_PARITY_EN
//   Defined   : the frame carries a trailing parity bit (state PAR). A parity
//               mismatch drops the frame and pulses parity_err.
//   Undefined : there is no parity bit, and parity_err stays 0.
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   rst          synchronous reset, active-high
//   bus_valid    bus_data carries a frame bit this cycle
//   bus_data     serial frame bit from the master mux
//   slave_ready  the slave accepts frame bits this cycle
//   slave_valid  tx_data carries a read-data bit
//   tx_data      serial read data, LSB first
//   rx_done      one-cycle pulse when a write commits
//   parity_err   one-cycle pulse when a frame is dropped on a parity mismatch
module slave_serial_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic bus_valid,
    input  logic bus_data,
    output logic slave_ready,
    output logic slave_valid,
    output logic tx_data,
    output logic rx_done,
    output logic parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAXW + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_PAR, S_COMMIT, S_RD_WAIT, S_TX
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    is_write;
    logic                    par_acc;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic accept;
    logic gap_expire;

    assign accept     = bus_valid && slave_ready;
    // Fires on the idle cycle that would bring the gap count up to TIMEOUT.
    assign gap_expire = (TIMEOUT != 0) && (gap_cnt == GAP_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            slave_ready <= 1'b0;
            slave_valid <= 1'b0;
            tx_data     <= 1'b0;
            rx_done     <= 1'b0;
            parity_err  <= 1'b0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            is_write    <= 1'b0;
            par_acc     <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rdata       <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    slave_ready <= 1'b1;
                    if (accept) begin
                        is_write <= bus_data;
                        par_acc  <= bus_data;
                        bit_cnt  <= '0;
                        gap_cnt  <= '0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        addr    <= (addr >> 1) | (ADDR_WIDTH'(bus_data) << (ADDR_WIDTH - 1));
                        par_acc <= par_acc ^ bus_data;
                        gap_cnt <= '0;
                        if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            if (is_write) begin
                                state <= S_WDATA;
                            end else begin
`ifdef SLAVE_PARITY_EN
                                state <= S_PAR;
`else
                                state       <= S_RD_WAIT;
                                slave_ready <= 1'b0;
`endif
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (gap_expire) begin
                        state   <= S_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_WDATA: begin
                    if (accept) begin
                        wdata   <= (wdata >> 1) | (DATA_WIDTH'(bus_data) << (DATA_WIDTH - 1));
                        par_acc <= par_acc ^ bus_data;
                        gap_cnt <= '0;
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
`ifdef SLAVE_PARITY_EN
                            state <= S_PAR;
`else
                            state       <= S_COMMIT;
                            slave_ready <= 1'b0;
                            rx_done     <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (gap_expire) begin
                        state   <= S_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_PAR: begin
                    // Even parity: the XOR of every frame bit, the parity bit included, must be 0.
                    if (accept) begin
                        gap_cnt <= '0;
                        if (par_acc ^ bus_data) begin
                            parity_err <= 1'b1;
                            state      <= S_IDLE;
                        end else if (is_write) begin
                            state       <= S_COMMIT;
                            slave_ready <= 1'b0;
                            rx_done     <= 1'b1;
                        end else begin
                            state       <= S_RD_WAIT;
                            slave_ready <= 1'b0;
                        end
                    end else if (gap_expire) begin
                        state   <= S_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_COMMIT: begin
                    mem[addr]   <= wdata;
                    state       <= S_IDLE;
                    slave_ready <= 1'b1;
                end
                S_RD_WAIT: begin
                    // Bit 0 goes straight to tx_data. The shift register keeps the rest.
                    tx_data     <= mem[addr][0];
                    rdata       <= mem[addr] >> 1;
                    slave_valid <= 1'b1;
                    bit_cnt     <= '0;
                    state       <= S_TX;
                end
                S_TX: begin
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        slave_valid <= 1'b0;
                        tx_data     <= 1'b0;
                        bit_cnt     <= '0;
                        state       <= S_IDLE;
                        slave_ready <= 1'b1;
                    end else begin
                        tx_data <= rdata[0];
                        rdata   <= rdata >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    slave_valid <= 1'b0;
                    slave_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_serial_port.sv
// tb_slave_serial_port
// Directed bench for slave_serial_port: reset, write/read, mid-frame gaps,
// gap timeout, bits ignored while busy, reset during TX, and parity (with
// SLAVE_PARITY_EN defined).
module tb_slave_serial_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bus_valid = 1'b0;
    logic bus_data = 1'b0;
    logic slave_ready, slave_valid, tx_data, rx_done, parity_err;

    int checks = 0;
    int errors = 0;

`ifdef SLAVE_PARITY_EN
    logic par_flip = 1'b0;
`endif

    slave_serial_port #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .slave_ready (slave_ready),
        .slave_valid (slave_valid),
        .tx_data     (tx_data),
        .rx_done     (rx_done),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame. Before frame bit gap_pos, bus_valid drops for gap_len cycles.
    task automatic send_frame(input logic mode, input logic [3:0] a, input logic [7:0] d,
                              input int gap_pos, input int gap_len);
        logic q[$];
`ifdef SLAVE_PARITY_EN
        logic p;
`endif
        q.push_back(mode);
        for (int i = 0; i < 4; i++) q.push_back(a[i]);
        if (mode) for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef SLAVE_PARITY_EN
        p = par_flip;
        foreach (q[i]) p = p ^ q[i];
        q.push_back(p);
`endif
        foreach (q[i]) begin
            if (i == gap_pos) begin
                bus_valid = 1'b0;
                repeat (gap_len) tick();
            end
            bus_valid = 1'b1;
            bus_data  = q[i];
            tick();
        end
        bus_valid = 1'b0;
        bus_data  = 1'b0;
    endtask

    // Sends a read frame and collects the 8-cycle response. With hold_bus set,
    // bus_valid stays high through RD_WAIT and TX.
    task automatic read_expect(input logic [3:0] a, input logic [7:0] exp, input logic hold_bus,
                               input int gap_pos, input int gap_len, input string tag);
        logic [7:0] got = 8'h00;
        int nvalid = 0;
        int nready = 0;
        send_frame(1'b0, a, 8'h00, gap_pos, gap_len);
        check({tag, "_rdwait_valid"}, 32'(slave_valid), 32'd0);
        if (hold_bus) begin
            bus_valid = 1'b1;
            bus_data  = 1'b1;
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            if (slave_valid) nvalid++;
            if (slave_ready) nready++;
            got[i] = tx_data;
            tick();
        end
        bus_valid = 1'b0;
        bus_data  = 1'b0;
        check({tag, "_data"}, 32'(got), 32'(exp));
        check({tag, "_nvalid"}, 32'(nvalid), 32'd8);
        check({tag, "_ready_in_tx"}, 32'(nready), 32'd0);
        check({tag, "_end_valid"}, 32'(slave_valid), 32'd0);
        check({tag, "_end_ready"}, 32'(slave_ready), 32'd1);
    endtask

    initial begin
        logic [10:0] part;
        bit seen_rx;

        // Reset held for three cycles
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", 32'(slave_ready), 32'd0);
        check("rst_valid", 32'(slave_valid), 32'd0);
        check("rst_tx", 32'(tx_data), 32'd0);
        check("rst_rxdone", 32'(rx_done), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        rst = 1'b0;
        check("release_ready_pre", 32'(slave_ready), 32'd0);
        tick();
        check("release_ready", 32'(slave_ready), 32'd1);

        // Write 0xA7 to address 5, then read it back
        send_frame(1'b1, 4'h5, 8'hA7, -1, 0);
        check("wr5_rxdone", 32'(rx_done), 32'd1);
        check("wr5_ready_commit", 32'(slave_ready), 32'd0);
        check("wr5_perr", 32'(parity_err), 32'd0);
        tick();
        check("wr5_rxdone_pulse", 32'(rx_done), 32'd0);
        check("wr5_ready_after", 32'(slave_ready), 32'd1);
        read_expect(4'h5, 8'hA7, 1'b0, -1, 0, "rd5");

        // A 5-cycle gap after the second address bit leaves the frame intact
        read_expect(4'h5, 8'hA7, 1'b0, 3, 5, "rd5_gap5");

        // A 16-cycle gap mid-WDATA aborts a write of 0x3C to address 5
        part = {6'b111100, 4'h5, 1'b1};
        for (int i = 0; i < 11; i++) begin
            bus_valid = 1'b1;
            bus_data  = part[i];
            tick();
        end
        bus_valid = 1'b0;
        bus_data  = 1'b0;
        seen_rx = 1'b0;
        repeat (16) begin
            tick();
            if (rx_done) seen_rx = 1'b1;
        end
        check("timeout_no_rxdone", 32'(seen_rx), 32'd0);
        check("timeout_ready", 32'(slave_ready), 32'd1);
        read_expect(4'h5, 8'hA7, 1'b0, -1, 0, "rd5_after_abort");

        // Bits offered during RD_WAIT/TX are ignored; the next frame follows TX directly
        send_frame(1'b1, 4'h3, 8'h5A, -1, 0);
        check("wr3_rxdone", 32'(rx_done), 32'd1);
        tick();
        read_expect(4'h3, 8'h5A, 1'b1, -1, 0, "rd3_busy_bits");
        read_expect(4'h3, 8'h5A, 1'b0, -1, 0, "rd3_next");

        // Reset asserted at TX bit 3
        send_frame(1'b0, 4'h5, 8'h00, -1, 0);
        tick();
        repeat (3) tick();
        check("midtx_valid", 32'(slave_valid), 32'd1);
        check("midtx_bit3", 32'(tx_data), 32'd0);
        rst = 1'b1;
        tick();
        check("midtx_rst_valid", 32'(slave_valid), 32'd0);
        check("midtx_rst_ready", 32'(slave_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("midtx_release_ready", 32'(slave_ready), 32'd1);
        read_expect(4'h5, 8'h00, 1'b0, -1, 0, "rd5_cleared");
        read_expect(4'h3, 8'h00, 1'b0, -1, 0, "rd3_cleared");

`ifdef SLAVE_PARITY_EN
        // Wrong parity on a write of 0x01 to address 2
        par_flip = 1'b1;
        send_frame(1'b1, 4'h2, 8'h01, -1, 0);
        par_flip = 1'b0;
        check("par_bad_perr", 32'(parity_err), 32'd1);
        check("par_bad_rxdone", 32'(rx_done), 32'd0);
        tick();
        check("par_bad_perr_pulse", 32'(parity_err), 32'd0);
        read_expect(4'h2, 8'h00, 1'b0, -1, 0, "rd2_after_bad");
        send_frame(1'b1, 4'h2, 8'h01, -1, 0);
        check("par_good_rxdone", 32'(rx_done), 32'd1);
        check("par_good_perr", 32'(parity_err), 32'd0);
        tick();
        read_expect(4'h2, 8'h01, 1'b0, -1, 0, "rd2_after_good");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
